// File: rtl/interval_timer_ctl.sv
// interval_timer_ctl: host-programmable interval timer sequencing a
// loadable up-counter through LOAD / RUN with one-shot and periodic modes,
// a one-cycle terminal-count pulse and a sticky interrupt with overrun flag.
//
// Optional build macro: TIMER_CTL_PRESCALER_EN
//   defined   -> control d[7:4] sets prescale P, one tick every P+1 cycles
//   undefined -> tick every cycle, control d[7:4] ignored
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | counter frozen, busy low, waiting for a start write
// LOAD   | q takes the reload value (one cycle)
// RUN    | q counts up on each tick; expiry at all-ones
module interval_timer_ctl #(
    parameter int WIDTH = 8
) (
    input  logic             cp,
    input  logic             nmr,
    input  logic             nwr,
    input  logic             a,
    input  logic [WIDTH-1:0] d,
    input  logic             nack,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             irq,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] Q_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic             r_periodic;
    logic             r_tc;
    logic             r_irq;
    logic             r_ovf;

    logic w_wr_ctl;
    logic w_wr_rel;
    logic w_start;
    logic w_stop;
    logic w_tick;
    logic w_step;
    logic w_expire;
    logic w_load;

    assign w_wr_ctl = ~nwr & a;
    assign w_wr_rel = ~nwr & ~a;
    // stop has priority over start when both are set in one write
    assign w_stop   = w_wr_ctl & d[2];
    assign w_start  = w_wr_ctl & d[0] & ~d[2];

    // a count step only happens when no start/stop command preempts RUN
    assign w_step   = (r_state == S_RUN) && w_tick && !w_start && !w_stop;
    assign w_expire = w_step && (r_q == Q_MAX);
    assign w_load   = (r_state == S_LOAD) && !w_stop;

`ifdef TIMER_CTL_PRESCALER_EN
    logic [3:0] r_psc;
    logic [3:0] r_pcnt;

    assign w_tick = (r_pcnt == 4'd0);

    // prescale down-counter: reloaded with P in LOAD and on every tick
    always_ff @(posedge cp or negedge nmr) begin
        if (!nmr) begin
            r_psc  <= 4'd0;
            r_pcnt <= 4'd0;
        end else begin
            if (w_wr_ctl)
                r_psc <= d[7:4];
            if ((r_state == S_LOAD) || ((r_state == S_RUN) && w_tick))
                r_pcnt <= r_psc;
            else if (r_state == S_RUN)
                r_pcnt <= r_pcnt - 4'd1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // state register
    always_ff @(posedge cp or negedge nmr) begin
        if (!nmr)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // next-state decode; host commands override the sequencing
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop)
            w_state_nxt = S_IDLE;
        else if (w_start)
            w_state_nxt = S_LOAD;
        else begin
            case (r_state)
                S_LOAD:  w_state_nxt = S_RUN;
                S_RUN:   if (w_expire && !r_periodic) w_state_nxt = S_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // output decode
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // host-visible configuration registers
    always_ff @(posedge cp or negedge nmr) begin
        if (!nmr) begin
            r_reload   <= '0;
            r_periodic <= 1'b0;
        end else begin
            if (w_wr_rel)
                r_reload <= d;
            if (w_wr_ctl)
                r_periodic <= d[1];
        end
    end

    // counter: load, count, and wrap only via reload
    always_ff @(posedge cp or negedge nmr) begin
        if (!nmr)
            r_q <= '0;
        else if (w_load)
            r_q <= r_reload;
        else if (w_step) begin
            if (r_q != Q_MAX)
                r_q <= r_q + 1'b1;
            else if (r_periodic)
                r_q <= r_reload;
        end
    end

    // terminal-count pulse, interrupt and overrun flags
    always_ff @(posedge cp or negedge nmr) begin
        if (!nmr) begin
            r_tc  <= 1'b0;
            r_irq <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_tc <= w_expire;
            if (!nack) begin
                r_irq <= w_expire;
                r_ovf <= 1'b0;
            end else if (w_expire) begin
                r_irq <= 1'b1;
                r_ovf <= r_irq;
            end
        end
    end

    assign q   = r_q;
    assign tc  = r_tc;
    assign irq = r_irq;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_interval_timer_ctl.sv
// Directed bench for interval_timer_ctl (WIDTH=8): table of per-edge vectors
// plus hand sequences for asynchronous reset and the prescale option.
module tb_interval_timer_ctl;

    logic       cp   = 1'b0;
    logic       nmr  = 1'b0;
    logic       nwr  = 1'b1;
    logic       a    = 1'b0;
    logic [7:0] d    = 8'h00;
    logic       nack = 1'b1;
    logic [7:0] q;
    logic       busy, tc, irq, ovf;

    int checks = 0;
    int errors = 0;

    interval_timer_ctl #(.WIDTH(8)) dut (
        .cp(cp), .nmr(nmr), .nwr(nwr), .a(a), .d(d), .nack(nack),
        .q(q), .busy(busy), .tc(tc), .irq(irq), .ovf(ovf)
    );

    always #5 cp = ~cp;

    typedef struct {
        logic       nwr;
        logic       a;
        logic [7:0] d;
        logic       nack;
        logic [7:0] q;
        logic [3:0] flags;   // busy, tc, irq, ovf
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic w, input logic aa, input logic [7:0] dd,
                       input logic k, input logic [7:0] eq, input logic [3:0] ef);
        vec_t v;
        v.nwr = w; v.a = aa; v.d = dd; v.nack = k; v.q = eq; v.flags = ef;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] eq, input logic [3:0] ef);
        checks++;
        if ({q, busy, tc, irq, ovf} !== {eq, ef}) begin
            errors++;
            $display("FAIL %s: got q=%h busy/tc/irq/ovf=%b%b%b%b, required q=%h flags=%b",
                     name, q, busy, tc, irq, ovf, eq, ef);
        end
    endtask

    // drive inputs away from the edge, clock once, sample 1ns after the edge
    task automatic step(input logic w, input logic aa, input logic [7:0] dd, input logic k);
        nwr = w; a = aa; d = dd; nack = k;
        @(posedge cp);
        #1;
    endtask

    task automatic nop();
        step(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
        $fatal(1);
    end

    initial begin
        // one-shot, reload FC
        add(1,0,8'h00,1, 8'h00,4'b0000);
        add(0,0,8'hFC,1, 8'h00,4'b0000);
        add(0,1,8'h01,1, 8'h00,4'b1000);
        add(1,0,8'h00,1, 8'hFC,4'b1000);
        add(1,0,8'h00,1, 8'hFD,4'b1000);
        add(1,0,8'h00,1, 8'hFE,4'b1000);
        add(1,0,8'h00,1, 8'hFF,4'b1000);
        add(1,0,8'h00,1, 8'hFF,4'b0110);
        add(1,0,8'h00,1, 8'hFF,4'b0010);
        add(1,0,8'h00,0, 8'hFF,4'b0000);
        // periodic, reload FE, overrun, mid-run reload change to FD
        add(0,0,8'hFE,1, 8'hFF,4'b0000);
        add(0,1,8'h03,1, 8'hFF,4'b1000);
        add(1,0,8'h00,1, 8'hFE,4'b1000);
        add(1,0,8'h00,1, 8'hFF,4'b1000);
        add(1,0,8'h00,1, 8'hFE,4'b1110);
        add(1,0,8'h00,1, 8'hFF,4'b1010);
        add(1,0,8'h00,1, 8'hFE,4'b1111);
        add(0,0,8'hFD,1, 8'hFF,4'b1011);
        add(1,0,8'h00,0, 8'hFD,4'b1110);
        add(1,0,8'h00,1, 8'hFE,4'b1010);
        add(1,0,8'h00,1, 8'hFF,4'b1010);
        add(1,0,8'h00,1, 8'hFD,4'b1111);
        add(1,0,8'h00,0, 8'hFE,4'b1000);
        // start+stop, restart, stop
        add(0,1,8'h05,1, 8'hFE,4'b0000);
        add(1,0,8'h00,1, 8'hFE,4'b0000);
        add(0,1,8'h01,1, 8'hFE,4'b1000);
        add(1,0,8'h00,1, 8'hFD,4'b1000);
        add(1,0,8'h00,1, 8'hFE,4'b1000);
        add(0,1,8'h01,1, 8'hFE,4'b1000);
        add(1,0,8'h00,1, 8'hFD,4'b1000);
        add(0,1,8'h04,1, 8'hFD,4'b0000);
        add(1,0,8'h00,1, 8'hFD,4'b0000);

        // reset state
        repeat (2) @(posedge cp);
        #1;
        chk("reset_state", 8'h00, 4'b0000);
        nmr = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].nwr, tbl[i].a, tbl[i].d, tbl[i].nack);
            chk($sformatf("vec%0d", i), tbl[i].q, tbl[i].flags);
        end

        // asynchronous reset mid-RUN with irq set
        step(0,1,8'h03,1); chk("rst_load",   8'hFD, 4'b1000);
        nop();             chk("rst_q_fd",   8'hFD, 4'b1000);
        nop();             chk("rst_q_fe",   8'hFE, 4'b1000);
        nop();             chk("rst_q_ff",   8'hFF, 4'b1000);
        nop();             chk("rst_expire", 8'hFD, 4'b1110);
        #3 nmr = 1'b0;
        #1 chk("rst_async", 8'h00, 4'b0000);
        repeat (2) @(posedge cp);
        #1 chk("rst_held", 8'h00, 4'b0000);
        nmr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nop();
            chk($sformatf("rst_quiet%0d", i), 8'h00, 4'b0000);
        end

        // control 0x21: prescale 2 when the option is built in, ignored otherwise
        step(0,0,8'hFE,1); chk("psc_reload", 8'h00, 4'b0000);
        step(0,1,8'h21,1); chk("psc_load",   8'h00, 4'b1000);
        nop();             chk("psc_q_fe",   8'hFE, 4'b1000);
`ifdef TIMER_CTL_PRESCALER_EN
        nop(); chk("psc_hold1", 8'hFE, 4'b1000);
        nop(); chk("psc_hold2", 8'hFE, 4'b1000);
        nop(); chk("psc_tick1", 8'hFF, 4'b1000);
        nop(); chk("psc_hold3", 8'hFF, 4'b1000);
        nop(); chk("psc_hold4", 8'hFF, 4'b1000);
        nop(); chk("psc_expire", 8'hFF, 4'b0110);
`else
        nop(); chk("nopsc_tick", 8'hFF, 4'b1000);
        nop(); chk("nopsc_expire", 8'hFF, 4'b0110);
        nop(); chk("nopsc_tc_drop", 8'hFF, 4'b0010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
